// File: rtl/timer_pkg.sv
// Shared types, default sizes and helpers for the multi-channel timer.
package timer_pkg;

  // Per-channel FSM state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  // Default parameter values for the top level.
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_PRESC_W = 8;

  // Upper bounds used by the slice helper (WIDTH <= 64, NUM_CH <= 16).
  localparam int MAX_W   = 64;
  localparam int MAX_CH  = 16;
  localparam int MAX_VEC = MAX_W * MAX_CH;

  // Extract channel ch (each w bits wide) from a packed vector, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] ch_slice(
    input logic [MAX_VEC-1:0] vec,
    input int unsigned        ch,
    input int unsigned        w
  );
    logic [MAX_VEC-1:0] shifted;
    logic [MAX_W-1:0]   mask;
    shifted = vec >> (ch * w);
    mask    = {MAX_W{1'b1}} >> (MAX_W - w);
    return shifted[MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/PAUSE/DONE FSM, down counter and sticky pending flag.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic             i_oneshot,
  input  logic [WIDTH-1:0] i_load,
  input  logic             i_load_wr,
  input  logic             i_tick,
  input  logic             i_irq_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_running,
  output logic             o_pend,
  output logic             o_pend_next
);

  timer_state_t     r_state;
  timer_state_t     w_state_next;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic             r_pend;
  logic             w_pend_next;
  logic             w_set;
  logic             w_load_nz;

  assign w_load_nz = (i_load != '0);

  // State, count and pending flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_pend  <= w_pend_next;
    end
  end

  // Next-state and next-count logic; a load write always beats a coincident tick.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_set        = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_enable && w_load_nz) begin
          w_state_next = RUN;
          w_count_next = i_load;
        end
      end
      RUN: begin
        if (i_load_wr) begin
          if (!w_load_nz) begin
            w_state_next = IDLE;
          end else begin
            w_count_next = i_load;
          end
        end else if (!i_enable) begin
          w_state_next = PAUSE;
        end else if (i_tick) begin
          if (r_count != '0) begin
            w_count_next = r_count - 1'b1;
          end else if (!w_load_nz) begin
            // Terminal count with no reload value: retire quietly.
            w_state_next = IDLE;
          end else begin
            w_set = 1'b1;
            if (i_oneshot) begin
              w_state_next = DONE;
              w_count_next = '0;
            end else begin
              w_count_next = i_load;
            end
          end
        end
      end
      PAUSE: begin
        if (i_load_wr) begin
          if (!w_load_nz) begin
            w_state_next = IDLE;
          end else begin
            w_count_next = i_load;
          end
        end else if (i_enable) begin
          w_state_next = RUN;
        end
      end
      DONE: begin
        w_count_next = '0;
        if (i_load_wr && i_enable && w_load_nz) begin
          w_state_next = RUN;
          w_count_next = i_load;
        end else if (!i_enable) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // A new terminal-count set takes priority over a coincident clear.
  assign w_pend_next = w_set | (r_pend & ~i_irq_clr);

  assign o_count     = r_count;
  assign o_running   = (r_state == RUN);
  assign o_pend      = r_pend;
  assign o_pend_next = w_pend_next;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel down-counting timer: shared prescaler, NUM_CH channels, OR-ed interrupt.
module timer_multi
  import timer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       oneshot,
  input  logic [NUM_CH*WIDTH-1:0] load,
  input  logic [NUM_CH-1:0]       load_wr,
  input  logic [PRESC_W-1:0]      prescale,
  input  logic [NUM_CH-1:0]       irq_clr,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       irq_pend,
  output logic                    irq
);

  logic [PRESC_W-1:0] r_psc;
  logic               r_irq;
  logic               w_any_run;
  logic               w_tick;
  logic [NUM_CH-1:0]  w_pend_next;
  logic [WIDTH-1:0]   w_load_ch  [NUM_CH];
  logic [WIDTH-1:0]   w_count_ch [NUM_CH];

  assign w_any_run = |running;
  // ">=" lets a shrunken prescale take effect on the very next clock.
  assign w_tick    = w_any_run && (r_psc >= prescale);

  // Prescaler counter: idles at 0 while nothing runs, wraps on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psc <= '0;
    end else if (!w_any_run || w_tick) begin
      r_psc <= '0;
    end else begin
      r_psc <= r_psc + 1'b1;
    end
  end

  // Interrupt line registered alongside the pending flags it summarises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |w_pend_next;
    end
  end

  assign irq = r_irq;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_load_ch[gi] = WIDTH'(ch_slice(MAX_VEC'(load), gi, WIDTH));

      timer_channel #(
        .WIDTH(WIDTH)
      ) u_channel (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_enable   (enable[gi]),
        .i_oneshot  (oneshot[gi]),
        .i_load     (w_load_ch[gi]),
        .i_load_wr  (load_wr[gi]),
        .i_tick     (w_tick),
        .i_irq_clr  (irq_clr[gi]),
        .o_count    (w_count_ch[gi]),
        .o_running  (running[gi]),
        .o_pend     (irq_pend[gi]),
        .o_pend_next(w_pend_next[gi])
      );

      assign count[gi*WIDTH +: WIDTH] = w_count_ch[gi];
    end
  endgenerate

endmodule

// File: tb/tb_timer_multi.sv
// Directed testbench for timer_multi (WIDTH=32, NUM_CH=4, PRESC_W=8).
module tb_timer_multi;

  logic         clk;
  logic         rst_n;
  logic [3:0]   enable;
  logic [3:0]   oneshot;
  logic [127:0] load;
  logic [3:0]   load_wr;
  logic [7:0]   prescale;
  logic [3:0]   irq_clr;
  logic [127:0] count;
  logic [3:0]   running;
  logic [3:0]   irq_pend;
  logic         irq;

  int total = 0;
  int bad   = 0;

  timer_multi #(.WIDTH(32), .NUM_CH(4), .PRESC_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .oneshot (oneshot),
    .load    (load),
    .load_wr (load_wr),
    .prescale(prescale),
    .irq_clr (irq_clr),
    .count   (count),
    .running (running),
    .irq_pend(irq_pend),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    enable   = '0;
    oneshot  = '0;
    load     = '0;
    load_wr  = '0;
    prescale = '0;
    irq_clr  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (count !== 128'd0) begin bad++; $display("FAIL reset_count got=%h exp=0", count); end
    total++; if (running !== 4'd0) begin bad++; $display("FAIL reset_running got=%b exp=0000", running); end
    total++; if (irq_pend !== 4'd0) begin bad++; $display("FAIL reset_pend got=%b exp=0000", irq_pend); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    $display("test_reset: checked");
  endtask

  task automatic test_periodic();
    int   exp_cnt;
    logic exp_pend;
    do_reset();
    load[31:0] = 32'd3;
    enable[0]  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      irq_clr[0] = 1'b0;
      exp_cnt  = 3 - ((k - 1) % 4);
      exp_pend = (k > 1) && ((k - 1) % 4 == 0);
      total++; if (count[31:0] !== 32'(exp_cnt)) begin bad++; $display("FAIL periodic_count k=%0d got=%0d exp=%0d", k, count[31:0], exp_cnt); end
      total++; if (irq_pend[0] !== exp_pend) begin bad++; $display("FAIL periodic_pend k=%0d got=%b exp=%b", k, irq_pend[0], exp_pend); end
      total++; if (irq !== exp_pend) begin bad++; $display("FAIL periodic_irq k=%0d got=%b exp=%b", k, irq, exp_pend); end
      total++; if (running[0] !== 1'b1) begin bad++; $display("FAIL periodic_running k=%0d got=%b exp=1", k, running[0]); end
      irq_clr[0] = exp_pend;
    end
    $display("test_periodic: checked");
  endtask

  task automatic test_prescale();
    int   exp_cnt;
    logic exp_pend;
    do_reset();
    prescale    = 8'd2;
    load[63:32] = 32'd1;
    enable[1]   = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      irq_clr[1] = 1'b0;
      exp_cnt  = (((k - 1) / 3) % 2 == 0) ? 1 : 0;
      exp_pend = (k > 1) && ((k - 1) % 6 == 0);
      total++; if (count[63:32] !== 32'(exp_cnt)) begin bad++; $display("FAIL presc_count k=%0d got=%0d exp=%0d", k, count[63:32], exp_cnt); end
      total++; if (irq_pend[1] !== exp_pend) begin bad++; $display("FAIL presc_pend k=%0d got=%b exp=%b", k, irq_pend[1], exp_pend); end
      irq_clr[1] = exp_pend;
    end
    $display("test_prescale: checked");
  endtask

  task automatic test_oneshot();
    do_reset();
    oneshot[2]   = 1'b1;
    load[95:64]  = 32'd5;
    enable[2]    = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 6) begin
        total++; if (count[95:64] !== 32'(6 - k)) begin bad++; $display("FAIL oneshot_count k=%0d got=%0d exp=%0d", k, count[95:64], 6 - k); end
        total++; if (running[2] !== 1'b1) begin bad++; $display("FAIL oneshot_running k=%0d got=%b exp=1", k, running[2]); end
        total++; if (irq_pend[2] !== 1'b0) begin bad++; $display("FAIL oneshot_pend k=%0d got=%b exp=0", k, irq_pend[2]); end
      end else begin
        total++; if (count[95:64] !== 32'd0) begin bad++; $display("FAIL oneshot_done_count k=%0d got=%0d exp=0", k, count[95:64]); end
        total++; if (running[2] !== 1'b0) begin bad++; $display("FAIL oneshot_done_running k=%0d got=%b exp=0", k, running[2]); end
        total++; if (irq_pend[2] !== 1'b1) begin bad++; $display("FAIL oneshot_done_pend k=%0d got=%b exp=1", k, irq_pend[2]); end
      end
    end
    load[95:64] = 32'd2;
    load_wr[2]  = 1'b1;
    irq_clr[2]  = 1'b1;
    for (int k = 11; k <= 14; k++) begin
      @(negedge clk);
      load_wr[2] = 1'b0;
      irq_clr[2] = 1'b0;
      if (k <= 13) begin
        total++; if (count[95:64] !== 32'(13 - k)) begin bad++; $display("FAIL restart_count k=%0d got=%0d exp=%0d", k, count[95:64], 13 - k); end
        total++; if (running[2] !== 1'b1) begin bad++; $display("FAIL restart_running k=%0d got=%b exp=1", k, running[2]); end
        total++; if (irq_pend[2] !== 1'b0) begin bad++; $display("FAIL restart_pend k=%0d got=%b exp=0", k, irq_pend[2]); end
      end else begin
        total++; if (count[95:64] !== 32'd0) begin bad++; $display("FAIL restart_done_count got=%0d exp=0", count[95:64]); end
        total++; if (running[2] !== 1'b0) begin bad++; $display("FAIL restart_done_running got=%b exp=0", running[2]); end
        total++; if (irq_pend[2] !== 1'b1) begin bad++; $display("FAIL restart_done_pend got=%b exp=1", irq_pend[2]); end
      end
    end
    $display("test_oneshot: checked");
  endtask

  task automatic test_pause();
    int   exp_cnt;
    logic exp_run;
    logic exp_pend;
    do_reset();
    load[31:0] = 32'd3;
    enable[0]  = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1)       exp_cnt = 3;
      else if (k <= 13) exp_cnt = 2;
      else if (k == 14) exp_cnt = 1;
      else if (k == 15) exp_cnt = 0;
      else              exp_cnt = 3;
      exp_run  = !(k >= 3 && k <= 12);
      exp_pend = (k == 16);
      total++; if (count[31:0] !== 32'(exp_cnt)) begin bad++; $display("FAIL pause_count k=%0d got=%0d exp=%0d", k, count[31:0], exp_cnt); end
      total++; if (running[0] !== exp_run) begin bad++; $display("FAIL pause_running k=%0d got=%b exp=%b", k, running[0], exp_run); end
      total++; if (irq_pend[0] !== exp_pend) begin bad++; $display("FAIL pause_pend k=%0d got=%b exp=%b", k, irq_pend[0], exp_pend); end
      if (k == 2)  enable[0] = 1'b0;
      if (k == 12) enable[0] = 1'b1;
    end
    $display("test_pause: checked");
  endtask

  task automatic test_collision();
    do_reset();
    load[31:0] = 32'd3;
    enable[0]  = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (count[31:0] !== 32'd0) begin bad++; $display("FAIL coll_pre_count got=%0d exp=0", count[31:0]); end
    irq_clr[0] = 1'b1;
    @(negedge clk);
    total++; if (irq_pend[0] !== 1'b1) begin bad++; $display("FAIL coll_set_wins got=%b exp=1", irq_pend[0]); end
    total++; if (count[31:0] !== 32'd3) begin bad++; $display("FAIL coll_reload got=%0d exp=3", count[31:0]); end
    irq_clr[0] = 1'b0;
    load[31:0] = 32'd7;
    load_wr[0] = 1'b1;
    @(negedge clk);
    load_wr[0] = 1'b0;
    total++; if (count[31:0] !== 32'd7) begin bad++; $display("FAIL coll_loadwr got=%0d exp=7", count[31:0]); end
    total++; if (running[0] !== 1'b1) begin bad++; $display("FAIL coll_loadwr_running got=%b exp=1", running[0]); end
    total++; if (irq_pend[0] !== 1'b1) begin bad++; $display("FAIL coll_pend_held got=%b exp=1", irq_pend[0]); end
    @(negedge clk);
    total++; if (count[31:0] !== 32'd6) begin bad++; $display("FAIL coll_after_load got=%0d exp=6", count[31:0]); end
    $display("test_collision: checked");
  endtask

  task automatic test_load_zero();
    do_reset();
    enable[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total++; if (running[3] !== 1'b0) begin bad++; $display("FAIL zero_running k=%0d got=%b exp=0", k, running[3]); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL zero_irq k=%0d got=%b exp=0", k, irq); end
      total++; if (count[127:96] !== 32'd0) begin bad++; $display("FAIL zero_count k=%0d got=%0d exp=0", k, count[127:96]); end
    end
    load[31:0] = 32'd2;
    enable[0]  = 1'b1;
    @(negedge clk);
    total++; if (count[31:0] !== 32'd2) begin bad++; $display("FAIL zterm_start got=%0d exp=2", count[31:0]); end
    load[31:0] = 32'd0;
    repeat (2) @(negedge clk);
    total++; if (count[31:0] !== 32'd0) begin bad++; $display("FAIL zterm_count got=%0d exp=0", count[31:0]); end
    total++; if (running[0] !== 1'b1) begin bad++; $display("FAIL zterm_pre_running got=%b exp=1", running[0]); end
    @(negedge clk);
    total++; if (running[0] !== 1'b0) begin bad++; $display("FAIL zterm_idle got=%b exp=0", running[0]); end
    total++; if (irq_pend[0] !== 1'b0) begin bad++; $display("FAIL zterm_pend got=%b exp=0", irq_pend[0]); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL zterm_irq got=%b exp=0", irq); end
    $display("test_load_zero: checked");
  endtask

  task automatic test_async_reset();
    do_reset();
    load[31:0] = 32'd3;
    enable[0]  = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (irq_pend[0] !== 1'b1) begin bad++; $display("FAIL areset_pre_pend got=%b exp=1", irq_pend[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (count !== 128'd0) begin bad++; $display("FAIL areset_count got=%h exp=0", count); end
    total++; if (running !== 4'd0) begin bad++; $display("FAIL areset_running got=%b exp=0000", running); end
    total++; if (irq_pend !== 4'd0) begin bad++; $display("FAIL areset_pend got=%b exp=0000", irq_pend); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL areset_irq got=%b exp=0", irq); end
    enable = '0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_async_reset: checked");
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = '0;
    oneshot  = '0;
    load     = '0;
    load_wr  = '0;
    prescale = '0;
    irq_clr  = '0;
    test_reset();
    test_periodic();
    test_prescale();
    test_oneshot();
    test_pause();
    test_collision();
    test_load_zero();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
